nec_ir_receiver: RTL and testbench

- Decodes NEC infrared remote frames from a single digital IR input.
- Sits in the user project area behind a GPIO pad; firmware reads the decoded address and command through a valid/ready holding register.
- Handles leader, 32 data bits (LSB first: addr, ~addr, data, ~data), stop mark and repeat codes.
- Timing tolerance comes from oversampling at 8 samples per protocol tick.

---
 rtl/nec_ir_pkg.sv | 38 +++
 rtl/nec_ir_sampler.sv | 74 +++++++
 rtl/nec_ir_receiver.sv | 195 +++++++++++++++++++
 tb/tb_nec_ir_receiver.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nec_ir_pkg.sv
// Shared types and timing constants for the NEC IR receiver.
// Windows are in sample units, with 8 samples per 562.5 us protocol tick.
package nec_ir_pkg;

   localparam int SAMPLES_PER_TICK = 8;
   localparam int FRAME_BITS       = 32;

   localparam logic [7:0] LEAD_MARK_MIN  = 8'(14 * SAMPLES_PER_TICK);
   localparam logic [7:0] LEAD_MARK_MAX  = 8'(18 * SAMPLES_PER_TICK);
   localparam logic [7:0] LEAD_SPACE_MIN = 8'(7 * SAMPLES_PER_TICK);
   localparam logic [7:0] LEAD_SPACE_MAX = 8'(9 * SAMPLES_PER_TICK);
   localparam logic [7:0] REP_SPACE_MIN  = 8'(3 * SAMPLES_PER_TICK);
   localparam logic [7:0] REP_SPACE_MAX  = 8'(5 * SAMPLES_PER_TICK);
   localparam logic [7:0] BIT_MARK_MIN   = 8'd4;
   localparam logic [7:0] BIT_MARK_MAX   = 8'd12;
   localparam logic [7:0] ZERO_SPACE_MIN = 8'd4;
   localparam logic [7:0] ZERO_SPACE_MAX = 8'd12;
   localparam logic [7:0] ONE_SPACE_MIN  = 8'd18;
   localparam logic [7:0] ONE_SPACE_MAX  = 8'd30;
   localparam logic [7:0] SPACE_TIMEOUT  = 8'(5 * SAMPLES_PER_TICK);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEAD_MARK,
      ST_LEAD_SPACE,
      ST_BIT_MARK,
      ST_BIT_SPACE,
      ST_STOP_MARK,
      ST_REP_STOP
   } state_t;

   function automatic logic in_window(input logic [7:0] dur,
                                      input logic [7:0] lo,
                                      input logic [7:0] hi);
      return (dur >= lo) && (dur <= hi);
   endfunction

endpackage

// File: rtl/nec_ir_sampler.sv
// IR input conditioning: 2-flop synchronizer, mark normalisation, sample
// prescaler and a saturating per-segment duration counter in samples.
module nec_ir_sampler #(
   parameter int   SAMPLE_DIV = 281,
   parameter logic IR_ACTIVE  = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_enable,
   input  logic       i_ir,
   output logic       o_strobe,
   output logic       o_edge,
   output logic       o_level,
   output logic [7:0] o_seg_dur,
   output logic [7:0] o_cur_dur
);

   localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   logic [1:0]       r_sync;
   logic [DIV_W-1:0] r_div;
   logic             r_level;
   logic [7:0]       r_dur;
   logic             r_strobe;
   logic             r_edge;
   logic [7:0]       r_seg_dur;
   logic             w_mark;
   logic             w_tick;

   assign w_mark = (r_sync[1] == IR_ACTIVE);
   assign w_tick = (r_div == DIV_W'(SAMPLE_DIV - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync    <= {2{~IR_ACTIVE}};
         r_div     <= '0;
         r_level   <= 1'b0;
         r_dur     <= '0;
         r_strobe  <= 1'b0;
         r_edge    <= 1'b0;
         r_seg_dur <= '0;
      end else begin
         r_sync   <= {r_sync[0], i_ir};
         r_strobe <= 1'b0;
         r_edge   <= 1'b0;
         if (!i_enable) begin
            r_div   <= '0;
            r_level <= 1'b0;
            r_dur   <= '0;
         end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
               r_strobe <= 1'b1;
               // The sample that sees the new level is the first one of its segment.
               if (w_mark != r_level) begin
                  r_level   <= w_mark;
                  r_edge    <= 1'b1;
                  r_seg_dur <= r_dur;
                  r_dur     <= 8'd1;
               end else if (r_dur != 8'hFF) begin
                  r_dur <= r_dur + 8'd1;
               end
            end
         end
      end
   end

   assign o_strobe  = r_strobe;
   assign o_edge    = r_edge;
   assign o_level   = r_level;
   assign o_seg_dur = r_seg_dur;
   assign o_cur_dur = r_dur;

endmodule

// File: rtl/nec_ir_receiver.sv
// NEC IR frame decoder with a valid/ready holding register for firmware.
// Define NEC_IR_STRICT_CHECK_EN to reject frames whose inverse bytes mismatch.
module nec_ir_receiver
   import nec_ir_pkg::*;
#(
   parameter int   SAMPLE_DIV = 281,
   parameter logic IR_ACTIVE  = 1'b1
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       enable_i,
   input  logic       ir_i,
   output logic       frame_valid_o,
   input  logic       frame_ready_i,
   output logic [7:0] frame_addr_o,
   output logic [7:0] frame_data_o,
   output logic       frame_repeat_o,
   output logic       overflow_o,
   output logic       error_o
);

   logic       w_strobe;
   logic       w_edge;
   logic       w_level;
   logic [7:0] w_seg_dur;
   logic [7:0] w_cur_dur;

   nec_ir_sampler #(
      .SAMPLE_DIV (SAMPLE_DIV),
      .IR_ACTIVE  (IR_ACTIVE)
   ) u_sampler (
      .i_clk     (wb_clk_i),
      .i_rst     (wb_rst_i),
      .i_enable  (enable_i),
      .i_ir      (ir_i),
      .o_strobe  (w_strobe),
      .o_edge    (w_edge),
      .o_level   (w_level),
      .o_seg_dur (w_seg_dur),
      .o_cur_dur (w_cur_dur)
   );

   state_t      r_state;
   logic [4:0]  r_bit_cnt;
   logic [15:0] r_word;
   logic        r_valid;
   logic        r_seen;
   logic [7:0]  r_addr;
   logic [7:0]  r_data;
   logic        r_repeat;
   logic        r_overflow;
   logic        r_error;

   logic       w_mark_end;
   logic       w_space_end;
   logic       w_bit_one;
   logic       w_bit_ok;
   logic       w_stop_ok;
   logic       w_frame_ok;
   logic [3:0] w_bit_idx;

   assign w_mark_end  = w_edge & ~w_level;
   assign w_space_end = w_edge & w_level;
   assign w_bit_one   = in_window(w_seg_dur, ONE_SPACE_MIN, ONE_SPACE_MAX);
   assign w_bit_ok    = w_bit_one | in_window(w_seg_dur, ZERO_SPACE_MIN, ZERO_SPACE_MAX);
   assign w_stop_ok   = in_window(w_seg_dur, BIT_MARK_MIN, BIT_MARK_MAX);
   // Bits 0-7 (addr) land in r_word[7:0], bits 16-23 (data) in r_word[15:8].
   assign w_bit_idx   = {r_bit_cnt[4], r_bit_cnt[2:0]};

`ifdef NEC_IR_STRICT_CHECK_EN
   logic [15:0] r_inv;
   assign w_frame_ok = ((r_word[7:0]  ^ r_inv[7:0])  == 8'hFF) &&
                       ((r_word[15:8] ^ r_inv[15:8]) == 8'hFF);
`else
   assign w_frame_ok = 1'b1;
`endif

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state    <= ST_IDLE;
         r_bit_cnt  <= '0;
         r_word     <= '0;
`ifdef NEC_IR_STRICT_CHECK_EN
         r_inv      <= '0;
`endif
         r_valid    <= 1'b0;
         r_seen     <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
         r_repeat   <= 1'b0;
         r_overflow <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_repeat   <= 1'b0;
         r_overflow <= 1'b0;
         r_error    <= 1'b0;
         // NOTE: last non-blocking assignment wins, so a frame loading below in
         // the same cycle as this handshake clear leaves r_valid set.
         if (r_valid && frame_ready_i) r_valid <= 1'b0;

         if (!enable_i) begin
            r_state <= ST_IDLE;
         end else if (w_strobe) begin
            unique case (r_state)
               ST_IDLE: begin
                  if (w_space_end) r_state <= ST_LEAD_MARK;
               end
               ST_LEAD_MARK: begin
                  if (w_mark_end) begin
                     if (in_window(w_seg_dur, LEAD_MARK_MIN, LEAD_MARK_MAX)) begin
                        r_state <= ST_LEAD_SPACE;
                     end else begin
                        r_state <= ST_IDLE;
                        r_error <= 1'b1;
                     end
                  end
               end
               ST_LEAD_SPACE: begin
                  if (w_space_end) begin
                     r_bit_cnt <= '0;
                     if (in_window(w_seg_dur, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                        r_state <= ST_BIT_MARK;
                     end else if (in_window(w_seg_dur, REP_SPACE_MIN, REP_SPACE_MAX)) begin
                        r_state <= ST_REP_STOP;
                     end else begin
                        r_state <= ST_IDLE;
                        r_error <= 1'b1;
                     end
                  end
               end
               ST_BIT_MARK: begin
                  if (w_mark_end) begin
                     if (w_stop_ok) begin
                        r_state <= ST_BIT_SPACE;
                     end else begin
                        r_state <= ST_IDLE;
                        r_error <= 1'b1;
                     end
                  end
               end
               ST_BIT_SPACE: begin
                  if (w_space_end) begin
                     if (w_bit_ok) begin
                        if (!r_bit_cnt[3]) r_word[w_bit_idx] <= w_bit_one;
`ifdef NEC_IR_STRICT_CHECK_EN
                        else r_inv[w_bit_idx] <= w_bit_one;
`endif
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                        r_state   <= (r_bit_cnt == 5'(FRAME_BITS - 1)) ? ST_STOP_MARK
                                                                       : ST_BIT_MARK;
                     end else begin
                        r_state <= ST_IDLE;
                        r_error <= 1'b1;
                     end
                  end else if (w_cur_dur > SPACE_TIMEOUT) begin
                     r_state <= ST_IDLE;
                     r_error <= 1'b1;
                  end
               end
               ST_STOP_MARK: begin
                  if (w_mark_end) begin
                     r_state <= ST_IDLE;
                     if (!w_stop_ok || !w_frame_ok) begin
                        r_error <= 1'b1;
                     end else if (r_valid && !frame_ready_i) begin
                        r_overflow <= 1'b1;
                     end else begin
                        r_valid <= 1'b1;
                        r_seen  <= 1'b1;
                        r_addr  <= r_word[7:0];
                        r_data  <= r_word[15:8];
                     end
                  end
               end
               ST_REP_STOP: begin
                  if (w_mark_end) begin
                     r_state <= ST_IDLE;
                     if (w_stop_ok) r_repeat <= r_seen;
                     else           r_error  <= 1'b1;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign frame_valid_o  = r_valid;
   assign frame_addr_o   = r_addr;
   assign frame_data_o   = r_data;
   assign frame_repeat_o = r_repeat;
   assign overflow_o     = r_overflow;
   assign error_o        = r_error;

endmodule

// File: tb/tb_nec_ir_receiver.sv
// Self-checking bench for nec_ir_receiver: a frame-level model of the holding
// register and pulse counts, compared every cycle, plus literal expectations.
module tb_nec_ir_receiver;

   localparam int SAMPLE_DIV = 2;
   localparam int TICK       = 8 * SAMPLE_DIV;
   localparam int MARGIN     = 8 * SAMPLE_DIV + 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       ir;
   logic       ready;
   logic       frame_valid;
   logic [7:0] frame_addr;
   logic [7:0] frame_data;
   logic       frame_repeat;
   logic       overflow;
   logic       error;

   nec_ir_receiver #(
      .SAMPLE_DIV (SAMPLE_DIV),
      .IR_ACTIVE  (1'b1)
   ) dut (
      .wb_clk_i       (clk),
      .wb_rst_i       (rst),
      .enable_i       (en),
      .ir_i           (ir),
      .frame_valid_o  (frame_valid),
      .frame_ready_i  (ready),
      .frame_addr_o   (frame_addr),
      .frame_data_o   (frame_data),
      .frame_repeat_o (frame_repeat),
      .overflow_o     (overflow),
      .error_o        (error)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Frame-level model: holding register contents and expected pulse totals.
   logic       m_valid = 1'b0;
   logic       m_seen  = 1'b0;
   logic [7:0] m_addr  = 8'h00;
   logic [7:0] m_data  = 8'h00;
   int         exp_err = 0;
   int         exp_ovf = 0;
   int         exp_rep = 0;
   int         n_err   = 0;
   int         n_ovf   = 0;
   int         n_rep   = 0;
   logic       settle  = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (error === 1'b1)        n_err++;
      if (overflow === 1'b1)     n_ovf++;
      if (frame_repeat === 1'b1) n_rep++;
      if (!settle)
         check("hold", 32'({frame_valid, frame_addr, frame_data}),
               32'({m_valid, m_addr, m_data}));
   end

   task automatic drive(input logic lvl, input int ticks);
      ir = lvl;
      repeat (ticks * TICK) @(negedge clk);
   endtask

   task automatic send_bits(input logic [31:0] word, input int nbits);
      drive(1'b1, 16);
      drive(1'b0, 8);
      for (int i = 0; i < nbits; i++) begin
         drive(1'b1, 1);
         drive(1'b0, word[i] ? 3 : 1);
      end
   endtask

   task automatic model_frame(input logic [7:0] a, na, d, nd);
      logic ok;
      ok = 1'b1;
`ifdef NEC_IR_STRICT_CHECK_EN
      ok = ((a ^ na) == 8'hFF) && ((d ^ nd) == 8'hFF);
`endif
      if (!en) return;
      if (!ok) exp_err++;
      else if (m_valid) exp_ovf++;
      else begin
         m_valid = 1'b1;
         m_seen  = 1'b1;
         m_addr  = a;
         m_data  = d;
      end
   endtask

   task automatic send_frame(input logic [7:0] a, na, d, nd);
      send_bits({nd, d, na, a}, 32);
      settle = 1'b1;
      drive(1'b1, 1);
      ir = 1'b0;
      repeat (MARGIN) @(negedge clk);
      model_frame(a, na, d, nd);
      settle = 1'b0;
      drive(1'b0, 4);
   endtask

   task automatic send_repeat();
      drive(1'b1, 16);
      drive(1'b0, 4);
      drive(1'b1, 1);
      ir = 1'b0;
      repeat (MARGIN) @(negedge clk);
      if (m_seen && en) exp_rep++;
      drive(1'b0, 4);
   endtask

   task automatic handshake();
      check("hs_valid_pre", 32'(frame_valid), 32'd1);
      @(negedge clk) ready = 1'b1;
      @(posedge clk);
      #1 ready = 1'b0;
      m_valid = 1'b0;
      @(negedge clk);
      check("hs_valid_post", 32'(frame_valid), 32'd0);
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_err_cnt"}, 32'(n_err), 32'(exp_err));
      check({tag, "_ovf_cnt"}, 32'(n_ovf), 32'(exp_ovf));
      check({tag, "_rep_cnt"}, 32'(n_rep), 32'(exp_rep));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"},  32'(frame_valid),  32'd0);
      check({tag, "_addr"},   32'(frame_addr),   32'd0);
      check({tag, "_data"},   32'(frame_data),   32'd0);
      check({tag, "_repeat"}, 32'(frame_repeat), 32'd0);
      check({tag, "_ovf"},    32'(overflow),     32'd0);
      check({tag, "_err"},    32'(error),        32'd0);
   endtask

   initial begin
      #900000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      rst   = 1'b1;
      en    = 1'b1;
      ir    = 1'b0;
      ready = 1'b0;
      repeat (5) @(negedge clk);
      check_all_zero("reset");
      rst    = 1'b0;
      settle = 1'b0;
      drive(1'b0, 4);

      // Repeat code before any frame: no pulse, no error.
      send_repeat();
      check_counts("rep_after_reset");

      send_frame(8'h5A, 8'hA5, 8'h3C, 8'hC3);
      check("f1_valid", 32'(frame_valid), 32'd1);
      check("f1_addr",  32'(frame_addr),  32'h5A);
      check("f1_data",  32'(frame_data),  32'h3C);
      check_counts("f1");

      send_repeat();
      check("rep_addr", 32'(frame_addr), 32'h5A);
      check("rep_data", 32'(frame_data), 32'h3C);
      check("rep_pulses", 32'(n_rep), 32'd1);
      handshake();

      // Second frame arrives while the first is unread.
      send_frame(8'h11, 8'hEE, 8'h22, 8'hDD);
      send_frame(8'h33, 8'hCC, 8'h44, 8'hBB);
      check("ovf_pulses", 32'(n_ovf), 32'd1);
      check("ovf_addr",   32'(frame_addr), 32'h11);
      check("ovf_data",   32'(frame_data), 32'h22);
      check_counts("ovf");
      handshake();

      // Leader mark of 10 ticks is out of window.
      drive(1'b1, 10);
      ir = 1'b0;
      repeat (MARGIN) @(negedge clk);
      exp_err++;
      drive(1'b0, 4);
      check("badlead_err", 32'(n_err), 32'd1);
      check("badlead_valid", 32'(frame_valid), 32'd0);
      send_frame(8'h80, 8'h7F, 8'hFF, 8'h00);
      check("f80_addr", 32'(frame_addr), 32'h80);
      check("f80_data", 32'(frame_data), 32'hFF);
      check_counts("f80");

      // Disabled receiver ignores the line but keeps the held frame.
      en = 1'b0;
      send_frame(8'h01, 8'hFE, 8'h02, 8'hFD);
      check("dis_addr", 32'(frame_addr), 32'h80);
      check_counts("disabled");
      handshake();
      en = 1'b1;
      drive(1'b0, 4);

      // Corrupted inverse address byte.
      send_frame(8'h12, 8'h00, 8'h34, 8'hCB);
`ifdef NEC_IR_STRICT_CHECK_EN
      check("strict_valid", 32'(frame_valid), 32'd0);
      check("strict_err",   32'(n_err),       32'd2);
`else
      check("lax_valid", 32'(frame_valid), 32'd1);
      check("lax_addr",  32'(frame_addr),  32'h12);
      check("lax_data",  32'(frame_data),  32'h34);
      handshake();
`endif
      check_counts("inv");

      // Reset during the mark of bit 10.
      send_bits({8'hA5, 8'h5A, 8'h5A, 8'hA5}, 10);
      ir = 1'b1;
      repeat (TICK / 2) @(negedge clk);
      settle = 1'b1;
      rst    = 1'b1;
      ir     = 1'b0;
      repeat (4) @(negedge clk);
      check_all_zero("midreset");
      m_valid = 1'b0;
      m_seen  = 1'b0;
      m_addr  = 8'h00;
      m_data  = 8'h00;
      rst     = 1'b0;
      settle  = 1'b0;
      drive(1'b0, 4);
      send_frame(8'hA5, 8'h5A, 8'h5A, 8'hA5);
      check("post_rst_valid", 32'(frame_valid), 32'd1);
      check("post_rst_addr",  32'(frame_addr),  32'hA5);
      check("post_rst_data",  32'(frame_data),  32'h5A);
      check_counts("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
